// File: rtl/de1_soc_pio_in_edge.sv
// Avalon-MM input PIO: per-channel synchroniser and debounce filter, edge-capture
// register with write-1-to-clear, and a maskable level interrupt.
module de1_soc_pio_in_edge #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      SYNC_STAGES     = 2,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter int unsigned      EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign sync         = sync_q[SYNC_STAGES-1];
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_LEVEL;
      end else begin
         sync_q[0] <= in_port;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) deb <= RESET_LEVEL;
            else          deb <= sync;
         end
      end else begin : g_debounce
         logic [CW-1:0] cnt [WIDTH];

         // Any cycle where sync agrees with deb restarts the stability count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb <= RESET_LEVEL;
               for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  if (sync[i] == deb[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                     deb[i] <= sync[i];
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CW'(1);
                  end
               end
            end
         end
      end
   endgenerate

   always_comb begin
      if (EDGE_TYPE == 0)      edge_pulse = prev & ~deb;
      else if (EDGE_TYPE == 1) edge_pulse = ~prev & deb;
      else                     edge_pulse = prev ^ deb;
   end

   assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // OR-ing the pulse after the clear lets a simultaneous new edge win.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev     <= RESET_LEVEL;
         edge_cap <= '0;
         irq_mask <= '0;
      end else begin
         prev     <= deb;
         edge_cap <= (edge_cap & ~clr) | edge_pulse;
         if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next[WIDTH-1:0] = deb;
         2'd2:    rd_next[WIDTH-1:0] = irq_mask;
         2'd3:    rd_next[WIDTH-1:0] = edge_cap;
         default: rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_de1_soc_pio_in_edge.sv
// Directed bench for de1_soc_pio_in_edge: one debounced falling-edge instance and
// one unfiltered any-edge instance sharing clock and reset.
`timescale 1ns/1ps
module tb_de1_soc_pio_in_edge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic [3:0]  in_port = 4'hF;

   logic [1:0]  b_address = '0;
   logic        b_chipselect = 1'b0;
   logic        b_write_n = 1'b1;
   logic [31:0] b_writedata = '0;
   logic [31:0] b_readdata;
   logic        b_irq;
   logic [3:0]  b_in_port = 4'hF;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   de1_soc_pio_in_edge #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0), .RESET_LEVEL(4'hF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .in_port(in_port)
   );

   de1_soc_pio_in_edge #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_LEVEL(4'hF)
   ) dut_any (
      .clk(clk), .reset_n(reset_n), .address(b_address), .chipselect(b_chipselect),
      .write_n(b_write_n), .writedata(b_writedata), .readdata(b_readdata), .irq(b_irq),
      .in_port(b_in_port)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      tick(1);
   endtask

   task automatic b_wr(input logic [1:0] a, input logic [31:0] d);
      b_address = a; b_writedata = d; b_chipselect = 1'b1; b_write_n = 1'b0;
      tick(1);
      b_chipselect = 1'b0; b_write_n = 1'b1;
   endtask

   task automatic b_rd(input logic [1:0] a);
      b_address = a;
      tick(1);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in_port = 4'hF; b_in_port = 4'hF;
      tick(2);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL reset_b_irq: got %b expected 0", b_irq); end
      reset_n = 1'b1;
      tick(20);
      rd(2'd0);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL reset_data: got %h expected %h", readdata, 32'hF); end
      rd(2'd1);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reserved_reg: got %h expected %h", readdata, 32'h0); end
      rd(2'd2);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected %h", readdata, 32'h0); end
      rd(2'd3);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_no_capture: got %h expected %h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_idle_irq: got %b expected 0", irq); end
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL mask_upper_bits: got %h expected %h", readdata, 32'hF); end
      wr(2'd2, 32'h0);
      rd(2'd2);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mask_clear: got %h expected %h", readdata, 32'h0); end
   endtask

   task automatic test_press;
      address = 2'd3;
      in_port = 4'hD;
      tick(11);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL capture_not_early: got %h expected %h", readdata, 32'h0); end
      tick(1);
      checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL capture_latency: got %h expected %h", readdata, 32'h2); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
      rd(2'd0);
      checks++; if (readdata !== 32'hD) begin errors++; $display("FAIL press_data: got %h expected %h", readdata, 32'hD); end
      wr(2'd2, 32'h2);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_mask: got %b expected 1", irq); end
   endtask

   task automatic test_glitch;
      in_port = 4'hC;
      tick(5);
      in_port = 4'hD;
      tick(20);
      rd(2'd0);
      checks++; if (readdata !== 32'hD) begin errors++; $display("FAIL glitch_data: got %h expected %h", readdata, 32'hD); end
      rd(2'd3);
      checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL glitch_capture: got %h expected %h", readdata, 32'h2); end
      repeat (3) begin
         in_port = 4'hC; tick(7);
         in_port = 4'hD; tick(1);
      end
      address = 2'd0;
      in_port = 4'hC;
      tick(10);
      checks++; if (readdata !== 32'hD) begin errors++; $display("FAIL bounce_hold: got %h expected %h", readdata, 32'hD); end
      tick(1);
      checks++; if (readdata !== 32'hC) begin errors++; $display("FAIL bounce_accept: got %h expected %h", readdata, 32'hC); end
      rd(2'd3);
      checks++; if (readdata !== 32'h3) begin errors++; $display("FAIL bounce_capture: got %h expected %h", readdata, 32'h3); end
      in_port = 4'hF;
      tick(20);
      rd(2'd0);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL release_data: got %h expected %h", readdata, 32'hF); end
      rd(2'd3);
      checks++; if (readdata !== 32'h3) begin errors++; $display("FAIL rising_ignored: got %h expected %h", readdata, 32'h3); end
      wr(2'd3, 32'h3);
      rd(2'd3);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h expected %h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b expected 0", irq); end
   endtask

   task automatic test_back_to_back;
      in_port = 4'hD;
      tick(10);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collide_pre_irq: got %b expected 0", irq); end
      wr(2'd3, 32'h2);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide_set_wins_irq: got %b expected 1", irq); end
      rd(2'd3);
      checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL collide_set_wins: got %h expected %h", readdata, 32'h2); end
      wr(2'd3, 32'h2);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq: got %b expected 0", irq); end
      checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL read_during_write: got %h expected %h", readdata, 32'h2); end
      tick(1);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL clear_capture: got %h expected %h", readdata, 32'h0); end
      in_port = 4'hF;
      tick(20);
      wr(2'd2, 32'h0);
   endtask

   task automatic test_any_edge;
      b_wr(2'd2, 32'h8);
      b_in_port = 4'h7;
      tick(3);
      checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL any_press_early: got %b expected 0", b_irq); end
      tick(1);
      checks++; if (b_irq !== 1'b1) begin errors++; $display("FAIL any_press_latency: got %b expected 1", b_irq); end
      b_wr(2'd3, 32'h8);
      checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL any_clear: got %b expected 0", b_irq); end
      b_in_port = 4'hF;
      tick(3);
      checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL any_release_early: got %b expected 0", b_irq); end
      tick(1);
      checks++; if (b_irq !== 1'b1) begin errors++; $display("FAIL any_release_latency: got %b expected 1", b_irq); end
      b_rd(2'd3);
      checks++; if (b_readdata !== 32'h8) begin errors++; $display("FAIL any_capture: got %h expected %h", b_readdata, 32'h8); end
      b_rd(2'd0);
      checks++; if (b_readdata !== 32'hF) begin errors++; $display("FAIL any_data: got %h expected %h", b_readdata, 32'hF); end
   endtask

   task automatic test_reset_mid_count;
      in_port = 4'hB;
      tick(7);
      reset_n = 1'b0;
      tick(1);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata: got %h expected %h", readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
      tick(1);
      address = 2'd0;
      reset_n = 1'b1;
      tick(1);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL midreset_data: got %h expected %h", readdata, 32'hF); end
      tick(9);
      checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL midreset_count_restart: got %h expected %h", readdata, 32'hF); end
      tick(1);
      checks++; if (readdata !== 32'hB) begin errors++; $display("FAIL midreset_accept: got %h expected %h", readdata, 32'hB); end
      address = 2'd3;
      tick(1);
      checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL midreset_capture: got %h expected %h", readdata, 32'h4); end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_back_to_back();
      test_any_edge();
      test_reset_mid_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
